// File: rtl/peripheral_mpi_apb4_arbiter.sv
// Round-robin arbiter funnelling NUM_MASTERS APB4 requesters onto one MPI slave.
// Optional ACCESS watchdog is built in when MPI_ARB_TIMEOUT_EN is defined.
module peripheral_mpi_apb4_arbiter #(
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 32,
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                   HCLK,
    input  logic                                   HRESETn,
    input  logic [NUM_MASTERS-1:0]                 m_PSEL,
    input  logic [NUM_MASTERS-1:0]                 m_PENABLE,
    input  logic [NUM_MASTERS-1:0]                 m_PWRITE,
    input  logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0]  m_PADDR,
    input  logic [NUM_MASTERS*APB_DATA_WIDTH-1:0]  m_PWDATA,
    output logic [APB_DATA_WIDTH-1:0]              m_PRDATA,
    output logic [NUM_MASTERS-1:0]                 m_PREADY,
    output logic [NUM_MASTERS-1:0]                 m_PSLVERR,
    output logic                                   s_PSEL,
    output logic                                   s_PENABLE,
    output logic                                   s_PWRITE,
    output logic [APB_ADDR_WIDTH-1:0]              s_PADDR,
    output logic [APB_DATA_WIDTH-1:0]              s_PWDATA,
    input  logic [APB_DATA_WIDTH-1:0]              s_PRDATA,
    input  logic                                   s_PREADY,
    input  logic                                   s_PSLVERR,
    output logic [NUM_MASTERS-1:0]                 grant_o,
    output logic                                   busy_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                    r_state;
    logic [IW-1:0]             r_last;
    logic [IW-1:0]             r_widx;
    logic [NUM_MASTERS-1:0]    r_grant;
    logic                      r_psel;
    logic                      r_pen;
    logic                      r_write;
    logic                      r_busy;
    logic                      r_drop;
    logic [APB_ADDR_WIDTH-1:0] r_addr;
    logic [APB_DATA_WIDTH-1:0] r_wdata;

    logic [IW-1:0]             w_win;
    logic [IW-1:0]             w_hi;
    logic [IW-1:0]             w_lo;
    logic                      w_hi_ok;
    logic [NUM_MASTERS-1:0]    w_win_oh;
    logic [APB_ADDR_WIDTH-1:0] w_addr;
    logic [APB_DATA_WIDTH-1:0] w_wdata;
    logic                      w_wr;
    logic                      w_keep;
    logic                      w_done;
    logic                      w_tout;
    logic                      w_resp;
    logic [NUM_MASTERS-1:0]    w_mask;
    logic                      w_unused;

    assign w_unused = ^m_PENABLE;

    // Round-robin pick: lowest requester above last winner, else lowest overall
    always_comb begin
        w_hi    = '0;
        w_lo    = '0;
        w_hi_ok = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_PSEL[i]) begin
                w_lo = IW'(i);
                if (IW'(i) > r_last) begin
                    w_hi    = IW'(i);
                    w_hi_ok = 1'b1;
                end
            end
        end
        w_win    = w_hi_ok ? w_hi : w_lo;
        w_win_oh = '0;
        w_win_oh[w_win] = 1'b1;
    end

    // Select the winner's address, data and direction for capture
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_wr    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_win == IW'(i)) begin
                w_addr  = m_PADDR[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                w_wdata = m_PWDATA[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                w_wr    = m_PWRITE[i];
            end
        end
    end

    // Owner loses its response once it has let go of PSEL during the transfer
    assign w_keep = ~r_drop & (|(m_PSEL & r_grant));
    assign w_done = (r_state == ACCESS) & s_PREADY;
    assign w_resp = w_done | w_tout;
    assign w_mask = r_grant & {NUM_MASTERS{w_resp & w_keep}};

    assign m_PREADY  = w_mask;
    assign m_PSLVERR = w_mask & {NUM_MASTERS{w_tout | s_PSLVERR}};
    assign m_PRDATA  = w_done ? s_PRDATA : '0;

`ifdef MPI_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;

    assign w_tout = (r_state == ACCESS) & ~s_PREADY
                  & (r_cnt == 16'(TIMEOUT_CYCLES));

    // Watchdog: count stalled ACCESS cycles, restart for every new transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt <= '0;
        end else if ((r_state == IDLE) && (|m_PSEL)) begin
            r_cnt <= '0;
        end else if ((r_state == ACCESS) && !s_PREADY && !w_tout) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign w_tout = 1'b0;
`endif

    // Sequencer: arbitrate in IDLE, then run APB setup/access on the slave
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
            r_psel  <= 1'b0;
            r_pen   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_grant <= '0;
            r_widx  <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|m_PSEL) begin
                        r_state <= SETUP;
                        r_psel  <= 1'b1;
                        r_pen   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_drop  <= 1'b0;
                        r_grant <= w_win_oh;
                        r_widx  <= w_win;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_write <= w_wr;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                    r_pen   <= 1'b1;
                    if (!w_keep) r_drop <= 1'b1;
                end
                ACCESS: begin
                    if (w_resp) begin
                        r_state <= IDLE;
                        r_psel  <= 1'b0;
                        r_pen   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_grant <= '0;
                        r_last  <= r_widx;
                    end else if (!w_keep) begin
                        r_drop  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_PSEL    = r_psel;
    assign s_PENABLE = r_pen;
    assign s_PWRITE  = r_write;
    assign s_PADDR   = r_addr;
    assign s_PWDATA  = r_wdata;
    assign grant_o   = r_grant;
    assign busy_o    = r_busy;

endmodule

// File: tb/tb_peripheral_mpi_apb4_arbiter.sv
// Scoreboard bench for the MPI APB4 arbiter: transaction-level model
// predicts owner, timing and response of every transfer.
module tb_peripheral_mpi_apb4_arbiter;

    localparam int NM = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    logic           HCLK = 1'b0;
    logic           HRESETn = 1'b1;
    logic [NM-1:0]  m_PSEL = '0;
    logic [NM-1:0]  m_PENABLE = '0;
    logic [NM-1:0]  m_PWRITE = '0;
    logic [NM*AW-1:0] m_PADDR = '0;
    logic [NM*DW-1:0] m_PWDATA = '0;
    logic [DW-1:0]  m_PRDATA;
    logic [NM-1:0]  m_PREADY;
    logic [NM-1:0]  m_PSLVERR;
    logic           s_PSEL;
    logic           s_PENABLE;
    logic           s_PWRITE;
    logic [AW-1:0]  s_PADDR;
    logic [DW-1:0]  s_PWDATA;
    logic [DW-1:0]  s_PRDATA = '0;
    logic           s_PREADY = 1'b0;
    logic           s_PSLVERR = 1'b0;
    logic [NM-1:0]  grant_o;
    logic           busy_o;

    peripheral_mpi_apb4_arbiter #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .NUM_MASTERS(NM),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE), .m_PWRITE(m_PWRITE),
        .m_PADDR(m_PADDR), .m_PWDATA(m_PWDATA), .m_PRDATA(m_PRDATA),
        .m_PREADY(m_PREADY), .m_PSLVERR(m_PSLVERR),
        .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE),
        .s_PADDR(s_PADDR), .s_PWDATA(s_PWDATA), .s_PRDATA(s_PRDATA),
        .s_PREADY(s_PREADY), .s_PSLVERR(s_PSLVERR),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int          m;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    // requester state
    bit          pend[NM];
    bit          infl[NM];
    logic [7:0]  raddr[NM];
    logic [31:0] rdat[NM];
    logic        rwr[NM];

    // transaction-level model of the arbiter + current transfer
    int          mdl_last = NM - 1;
    int          mdl_free = 0;
    int          cur_m = 0;
    int          cur_g = -100;
    int          cur_d = -100;
    int          cur_rdy = -100;
    logic [7:0]  cur_addr = '0;
    logic [31:0] cur_wd = '0;
    logic        cur_wr = 1'b0;
    logic [31:0] cur_rdata = '0;
    logic        cur_err = 1'b0;
    bit          cur_drop = 1'b0;

    // knobs
    logic [NM-1:0] k_mask = '0;
    int          k_reqpct = 0;
    int          k_wait = 0;
    int          k_err = 0;
    int          k_drop_pct = 0;
    int          k_to = 0;
    bit          k_rdfix = 1'b0;
    logic [31:0] k_rdata = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic step();
        int  w;
        int  idx;
        int  wt;
        bit  any;
        bit  to;
        bit  dr;
        logic er;
        logic [31:0] rd;
        @(posedge HCLK);
        #1;
        cyc++;
        for (int i = 0; i < NM; i++) begin
            if (infl[i] && cyc > cur_d) begin
                infl[i] = 1'b0;
                pend[i] = 1'b0;
            end
            if (infl[i] && cur_drop && cyc == cur_g + 1) pend[i] = 1'b0;
            if (!pend[i] && !infl[i] && k_mask[i]
                && ($urandom_range(0, 99) < k_reqpct)) begin
                pend[i]  = 1'b1;
                raddr[i] = 8'($urandom);
                rdat[i]  = $urandom;
                rwr[i]   = 1'($urandom);
            end
        end
        for (int i = 0; i < NM; i++) begin
            m_PSEL[i]            = pend[i];
            m_PENABLE[i]         = pend[i] & infl[i];
            m_PWRITE[i]          = rwr[i];
            m_PADDR[i*AW +: AW]  = raddr[i];
            m_PWDATA[i*DW +: DW] = rdat[i];
        end
        any = 1'b0;
        for (int i = 0; i < NM; i++) any |= pend[i];
        if (cyc >= mdl_free && any) begin
            w = -1;
            for (int k = 1; k <= NM; k++) begin
                idx = (mdl_last + k) % NM;
                if (w < 0 && pend[idx]) w = idx;
            end
            wt = (k_wait < 0) ? int'($urandom_range(0, 3)) : k_wait;
            er = (k_err < 0) ? 1'($urandom) : 1'(k_err);
            dr = ($urandom_range(0, 99) < k_drop_pct);
            rd = k_rdfix ? k_rdata : $urandom;
`ifdef MPI_ARB_TIMEOUT_EN
            to = (k_to < 0) ? ($urandom_range(0, 7) == 0) : (k_to != 0);
`else
            to = 1'b0;
`endif
            cur_m     = w;
            cur_g     = cyc;
            cur_addr  = raddr[w];
            cur_wd    = rdat[w];
            cur_wr    = rwr[w];
            cur_drop  = dr;
            cur_rdata = rd;
            cur_err   = er;
            cur_d     = cyc + 2 + (to ? TO : wt);
            cur_rdy   = to ? -1 : cur_d;
            mdl_free  = cur_d + 1;
            mdl_last  = w;
            infl[w]   = 1'b1;
            if (!dr) sbq.push_back('{w, cur_d,
                                     to ? 32'h0 : rd, to ? 1'b1 : er});
        end
        if (cyc == cur_rdy) begin
            s_PREADY  = 1'b1;
            s_PRDATA  = cur_rdata;
            s_PSLVERR = cur_err;
        end else if (cyc >= cur_g + 2 && cyc <= cur_d) begin
            s_PREADY  = 1'b0;
            s_PRDATA  = $urandom;
            s_PSLVERR = 1'($urandom);
        end else begin
            s_PREADY  = 1'($urandom);
            s_PRDATA  = $urandom;
            s_PSLVERR = 1'($urandom);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_reset();
        sbq.delete();
        for (int i = 0; i < NM; i++) begin
            pend[i] = 1'b0;
            infl[i] = 1'b0;
        end
        m_PSEL   = '0;
        mdl_last = NM - 1;
        mdl_free = 0;
        cur_g    = -100;
        cur_d    = -100;
        cur_rdy  = -100;
    endtask

    task automatic seed(int i, logic [7:0] a, logic [31:0] d, logic wr);
        pend[i]  = 1'b1;
        raddr[i] = a;
        rdat[i]  = d;
        rwr[i]   = wr;
    endtask

    // monitor: per-cycle bus checks and scoreboard pop on completion
    always @(negedge HCLK) begin
        exp_t e;
        bit   ep;
        bit   en;
        if (mon_en) begin
            ep = (cyc > cur_g) && (cyc <= cur_d);
            en = (cyc > cur_g + 1) && (cyc <= cur_d);
            chk("s_psel", s_PSEL, ep);
            chk("s_penable", s_PENABLE, en);
            chk("busy", busy_o, ep);
            chk("grant", grant_o, ep ? (64'd1 << cur_m) : 64'd0);
            if (ep) begin
                chk("s_paddr", s_PADDR, cur_addr);
                chk("s_pwdata", s_PWDATA, cur_wd);
                chk("s_pwrite", s_PWRITE, cur_wr);
            end
            if (m_PREADY != '0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pready", m_PREADY, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("pready_owner", m_PREADY, 64'd1 << e.m);
                    chk("pready_cycle", 64'(cyc), 64'(e.cyc));
                    chk("prdata", m_PRDATA, e.rdata);
                    chk("pslverr", m_PSLVERR, 64'(e.err) << e.m);
                end
            end else begin
                chk("pslverr_idle", m_PSLVERR, 0);
                if (cyc != cur_d) chk("prdata_idle", m_PRDATA, 0);
                if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
                    e = sbq.pop_front();
                    chk("missing_pready", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: time limit reached");
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        model_reset();
        #1 HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_s_psel", s_PSEL, 0);
        chk("rst_s_penable", s_PENABLE, 0);
        chk("rst_s_paddr", s_PADDR, 0);
        chk("rst_s_pwdata", s_PWDATA, 0);
        chk("rst_s_pwrite", s_PWRITE, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pready", m_PREADY, 0);
        HRESETn = 1'b1;
        mon_en  = 1'b1;

        // first transfer after reset: requester 0, zero-wait write
        k_mask = 2'b01; k_reqpct = 0; k_wait = 0; k_err = 0;
        seed(0, 8'h04, 32'hA5A5A5A5, 1'b1);
        run(5);

        // continuous contention: grants alternate
        k_mask = 2'b11; k_reqpct = 100;
        run(13);
        k_reqpct = 0;
        run(6);

        // 3 wait states, fixed read data, both requesting
        k_wait = 3; k_rdfix = 1'b1; k_rdata = 32'h12345678;
        seed(0, 8'h10, 32'h0, 1'b0);
        seed(1, 8'h20, 32'h0, 1'b0);
        run(14);
        k_rdfix = 1'b0;

        // slave error responses
        k_err = 1; k_wait = -1; k_reqpct = 100; k_mask = 2'b01;
        run(12);

`ifdef MPI_ARB_TIMEOUT_EN
        // stuck slave: watchdog answers with an error
        k_reqpct = 0; k_to = 1;
        run(8);
        seed(0, 8'h33, 32'h0, 1'b0);
        run(10);
        k_to = -1;
`endif

        // randomized mix including mid-transfer PSEL drops
        k_mask = 2'b11; k_reqpct = 40; k_wait = -1; k_err = -1;
        k_drop_pct = 12;
        run(400);

        // drain
        k_reqpct = 0; k_drop_pct = 0;
        run(30);
        chk("sb_empty", sbq.size(), 0);

        // reset during ACCESS
        k_to = 0; k_wait = 3; k_mask = 2'b01;
        seed(0, 8'h55, 32'hDEADBEEF, 1'b1);
        step();
        run(3);
        mon_en = 1'b0;
        chk("pre_rst_penable", s_PENABLE, 1);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_s_psel", s_PSEL, 0);
        chk("arst_s_penable", s_PENABLE, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_grant", grant_o, 0);
        chk("arst_pready", m_PREADY, 0);
        s_PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("rst_hold_pready", m_PREADY, 0);
        end
        model_reset();
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        mon_en = 1'b1;

        // last winner restored: requester 0 first again
        k_mask = 2'b11; k_wait = 0;
        seed(0, 8'h61, 32'h11111111, 1'b1);
        seed(1, 8'h62, 32'h22222222, 1'b1);
        run(10);
        chk("sb_empty_end", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
